// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: one holding slot per result producer, drained
// round-robin onto WRITE_PORTS RF write ports, with a pending-write mask for issue.

module rf_wb_slot #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          drain,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_data,
   output logic          occupied,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data
);
   // A load wins over a same-cycle drain; writes to register 0 never occupy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         occupied <= 1'b0;
         addr     <= '0;
         data     <= '0;
      end else if (load) begin
         occupied <= (in_addr != '0);
         addr     <= in_addr;
         data     <= in_data;
      end else if (drain) begin
         occupied <= 1'b0;
      end
   end
endmodule

module rf_writeback_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 32,
   parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
   parameter int NUM_SRC     = 4,
   parameter int WRITE_PORTS = 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_SRC-1:0]                      src_valid,
   output logic [NUM_SRC-1:0]                      src_ready,
   input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]      src_addr,
   input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]      src_data,
   output logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  write_addrs,
   output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  write_data,
   output logic [WRITE_PORTS-1:0]                  write_reg_enable,
   output logic [NUM_REGS-1:0]                     pending_mask
);
   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]                 occ, grant, load;
   logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] slot_addr;
   logic [NUM_SRC-1:0][DATA_WIDTH-1:0] slot_data;
   logic [PW-1:0]                      rr_ptr, rr_next;
   int                                 idx, np;
   logic                               dup;

   assign src_ready = ~occ | grant;
   assign load      = src_valid & src_ready;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
      rf_wb_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_slot (
         .clk      (clk),
         .rst      (rst),
         .load     (load[s]),
         .drain    (grant[s]),
         .in_addr  (src_addr[s]),
         .in_data  (src_data[s]),
         .occupied (occ[s]),
         .addr     (slot_addr[s]),
         .data     (slot_data[s])
      );
   end

   // Grants are suppressed while reset is asserted so discarded results never reach the RF.
   always_comb begin
      grant            = '0;
      write_reg_enable = '0;
      write_addrs      = '0;
      write_data       = '0;
      rr_next          = rr_ptr;
      idx              = 0;
      np               = 0;
      dup              = 1'b0;
      if (rst) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            for (int s = 0; s < NUM_SRC; s++) begin
               if (s == idx && occ[s] && np < WRITE_PORTS) begin
                  dup = 1'b0;
                  for (int p = 0; p < WRITE_PORTS; p++)
                     if (p < np && write_addrs[p] == slot_addr[s]) dup = 1'b1;
                  if (!dup) begin
                     grant[s] = 1'b1;
                     for (int p = 0; p < WRITE_PORTS; p++) begin
                        if (p == np) begin
                           write_reg_enable[p] = 1'b1;
                           write_addrs[p]      = slot_addr[s];
                           write_data[p]       = slot_data[s];
                        end
                     end
                     np      = np + 1;
                     rr_next = (s == NUM_SRC - 1) ? '0 : PW'(s + 1);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) rr_ptr <= '0;
      else      rr_ptr <= rr_next;
   end

   always_comb begin
      pending_mask = '0;
      for (int s = 0; s < NUM_SRC; s++)
         if (occ[s]) pending_mask[slot_addr[s]] = 1'b1;
   end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench: table of per-cycle vectors plus hand sequences for reset,
// same-address skipping on a two-port instance, and single-source streaming.

module tb_rf_writeback_arbiter;
   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        src_valid;
   logic [3:0][4:0]   src_addr;
   logic [3:0][31:0]  src_data;

   logic [3:0]        ready1, ready2;
   logic [0:0][4:0]   waddr1;
   logic [0:0][31:0]  wdata1;
   logic [0:0]        wen1;
   logic [31:0]       mask1, mask2;
   logic [1:0][4:0]   waddr2;
   logic [1:0][31:0]  wdata2;
   logic [1:0]        wen2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rf_writeback_arbiter #(.WRITE_PORTS(1)) dut1 (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(ready1),
      .src_addr(src_addr), .src_data(src_data), .write_addrs(waddr1),
      .write_data(wdata1), .write_reg_enable(wen1), .pending_mask(mask1)
   );

   rf_writeback_arbiter #(.WRITE_PORTS(2)) dut2 (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(ready2),
      .src_addr(src_addr), .src_data(src_data), .write_addrs(waddr2),
      .write_data(wdata2), .write_reg_enable(wen2), .pending_mask(mask2)
   );

   typedef struct {
      logic [3:0]       valid;
      logic [3:0][4:0]  addr;
      logic [3:0][31:0] data;
      logic             en;
      logic [4:0]       waddr;
      logic [31:0]      wdata;
      logic [31:0]      mask;
      logic [3:0]       ready;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(logic [3:0] v, logic [19:0] a, logic [127:0] d,
                               logic en, logic [4:0] wa, logic [31:0] wd,
                               logic [31:0] m, logic [3:0] r);
      vec_t t;
      t.valid = v; t.addr = a; t.data = d;
      t.en = en; t.waddr = wa; t.wdata = wd; t.mask = m; t.ready = r;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      src_valid = '0; src_addr = '0; src_data = '0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle(); rst = 1'b0; tick(); rst = 1'b1;
   endtask

   initial begin
      // contention from rr_ptr=0, round-robin continuation, single result, x0 drop
      vecs[0]  = mk(4'hF, {5'd4,5'd3,5'd2,5'd1}, {32'h44,32'h33,32'h22,32'h11},
                    1, 5'd1, 32'h11, 32'h1E, 4'b0001);
      vecs[1]  = mk(4'h0, '0, '0, 1, 5'd2, 32'h22, 32'h1C, 4'b0011);
      vecs[2]  = mk(4'h0, '0, '0, 1, 5'd3, 32'h33, 32'h18, 4'b0111);
      vecs[3]  = mk(4'h0, '0, '0, 1, 5'd4, 32'h44, 32'h10, 4'b1111);
      vecs[4]  = mk(4'h0, '0, '0, 0, 5'd0, 32'h0,  32'h0,  4'b1111);
      vecs[5]  = mk(4'h3, {5'd0,5'd0,5'd6,5'd5}, {32'h0,32'h0,32'h66,32'hDEADBEEF},
                    1, 5'd5, 32'hDEADBEEF, 32'h60, 4'b1101);
      vecs[6]  = mk(4'h0, '0, '0, 1, 5'd6, 32'h66, 32'h40, 4'b1111);
      vecs[7]  = mk(4'h0, '0, '0, 0, 5'd0, 32'h0,  32'h0,  4'b1111);
      vecs[8]  = mk(4'h1, {5'd0,5'd0,5'd0,5'd5}, {32'h0,32'h0,32'h0,32'hDEADBEEF},
                    1, 5'd5, 32'hDEADBEEF, 32'h20, 4'b1111);
      vecs[9]  = mk(4'h0, '0, '0, 0, 5'd0, 32'h0,  32'h0,  4'b1111);
      vecs[10] = mk(4'h4, {5'd0,5'd0,5'd0,5'd0}, {32'h0,32'h7,32'h0,32'h0},
                    0, 5'd0, 32'h0, 32'h0, 4'b1111);
      vecs[11] = mk(4'h0, '0, '0, 0, 5'd0, 32'h0,  32'h0,  4'b1111);

      // reset held with all sources offering
      rst = 1'b0;
      src_valid = 4'hF;
      src_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
      src_data  = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
      for (int c = 0; c < 2; c++) begin
         tick();
         chk($sformatf("rst%0d_en", c), 64'(wen1), 64'h0);
         chk($sformatf("rst%0d_mask", c), 64'(mask1), 64'h0);
         chk($sformatf("rst%0d_ready", c), 64'(ready1), 64'hF);
      end
      idle(); rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk($sformatf("post_rst%0d_en", c), 64'(wen1), 64'h0);
         chk($sformatf("post_rst%0d_mask", c), 64'(mask1), 64'h0);
      end

      for (int i = 0; i < 12; i++) begin
         src_valid = vecs[i].valid;
         src_addr  = vecs[i].addr;
         src_data  = vecs[i].data;
         tick();
         chk($sformatf("v%0d_en", i), 64'(wen1[0]), 64'(vecs[i].en));
         chk($sformatf("v%0d_addr", i), 64'(waddr1[0]), 64'(vecs[i].waddr));
         chk($sformatf("v%0d_data", i), 64'(wdata1[0]), 64'(vecs[i].wdata));
         chk($sformatf("v%0d_mask", i), 64'(mask1), 64'(vecs[i].mask));
         chk($sformatf("v%0d_ready", i), 64'(ready1), 64'(vecs[i].ready));
      end

      // mid-operation reset discards a held result
      idle(); src_valid = 4'b0010; src_addr[1] = 5'd7; src_data[1] = 32'h77;
      tick();
      chk("midrst_held_mask", 64'(mask1), 64'h80);
      idle(); rst = 1'b0; #1;
      chk("midrst_en_in_reset", 64'(wen1), 64'h0);
      tick();
      chk("midrst_mask", 64'(mask1), 64'h0);
      rst = 1'b1;
      tick();
      chk("midrst_after_en", 64'(wen1), 64'h0);

      // same destination from two sources on the two-port instance
      do_reset();
      src_valid = 4'b0011;
      src_addr  = {5'd0, 5'd0, 5'd9, 5'd9};
      src_data  = {32'h0, 32'h0, 32'hB1, 32'hA0};
      tick(); idle();
      chk("waw_c1_en", 64'(wen2), 64'b01);
      chk("waw_c1_addr0", 64'(waddr2[0]), 64'd9);
      chk("waw_c1_data0", 64'(wdata2[0]), 64'hA0);
      chk("waw_c1_ready", 64'(ready2), 64'b1101);
      chk("waw_c1_mask", 64'(mask2), 64'h200);
      tick();
      chk("waw_c2_en", 64'(wen2), 64'b01);
      chk("waw_c2_addr0", 64'(waddr2[0]), 64'd9);
      chk("waw_c2_data0", 64'(wdata2[0]), 64'hB1);
      tick();
      chk("waw_c3_en", 64'(wen2), 64'b00);
      chk("waw_c3_mask", 64'(mask2), 64'h0);

      // streaming from source 3 at one result per cycle
      do_reset();
      for (int i = 0; i < 8; i++) begin
         src_valid = 4'b1000;
         src_addr[3] = 5'(10 + i);
         src_data[3] = 32'h3000 + 32'(i);
         #1;
         chk($sformatf("stream%0d_ready", i), 64'(ready1[3]), 64'h1);
         tick();
         chk($sformatf("stream%0d_en", i), 64'(wen1[0]), 64'h1);
         chk($sformatf("stream%0d_addr", i), 64'(waddr1[0]), 64'(10 + i));
         chk($sformatf("stream%0d_data", i), 64'(wdata1[0]), 64'h3000 + 64'(i));
      end
      idle();
      tick();
      chk("stream_end_en", 64'(wen1), 64'h0);
      chk("stream_end_mask", 64'(mask1), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
